// File: rtl/ili9341_frame_scheduler_if.sv
// Bundle between the frame scheduler and its requesters/display controller.
//
// Handshake semantics: req bits are level requests that stay pending until
// the scheduler grants them, and the scheduler only grants from IDLE.
// pixel_ready is a single-cycle strobe from the controller meaning "consume
// the pixel on pixel_data now". It is not a held valid/ready pair, so each
// high cycle counts as exactly one transfer. grant/frame_start/frame_done are
// single-cycle pulses. busy is a level signal that covers the streaming phase.
interface ili9341_frame_scheduler_if #(
   parameter int PIXEL_SIZE = 16,
   parameter int N_REQ      = 5
);
   localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   logic [N_REQ-1:0]            req;
   logic [N_REQ*PIXEL_SIZE-1:0] req_color;
   logic                        pixel_ready;
   logic [PIXEL_SIZE-1:0]       pixel_data;
   logic [N_REQ-1:0]            grant;
   logic [ID_W-1:0]             active_id;
   logic                        busy;
   logic                        frame_start;
   logic                        frame_done;

   // Requester / controller side
   modport master (
      output req, req_color, pixel_ready,
      input  pixel_data, grant, active_id, busy, frame_start, frame_done
   );

   // Scheduler side
   modport slave (
      input  req, req_color, pixel_ready,
      output pixel_data, grant, active_id, busy, frame_start, frame_done
   );
endinterface

// File: rtl/ili9341_frame_scheduler.sv
// Round-robin frame scheduler: it picks one requester and streams a
// full frame of that requester's colour, one pixel per pixel_ready strobe.
// All outputs come straight from flops, so no input reaches an output
// combinationally.
module ili9341_frame_scheduler #(
   parameter int RESOLUTION = 320*240,
   parameter int PIXEL_SIZE = 16,
   parameter int N_REQ      = 5
) (
   input  logic                         clk,
   input  logic                         rst,
   ili9341_frame_scheduler_if.slave     bus,
   output logic [1:0]                   state_dbg
);
   localparam int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int CNT_W = (RESOLUTION > 1) ? $clog2(RESOLUTION) : 1;
   localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(RESOLUTION - 1);
   localparam logic [ID_W-1:0]  LAST_ID  = ID_W'(N_REQ - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      STREAM = 2'd1,
      DONE   = 2'd2
   } state_t;

   state_t                state_q, state_d;
   logic [ID_W-1:0]       ptr_q, ptr_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [PIXEL_SIZE-1:0] pix_q, pix_d;
   logic [N_REQ-1:0]      grant_q, grant_d;
   logic [ID_W-1:0]       id_q, id_d;
   logic                  busy_q, busy_d;
   logic                  fs_q, fs_d;
   logic                  fd_q, fd_d;

   logic                  found;
   logic [ID_W-1:0]       win;
   int                    idx;

   // Rotating search: start at ptr, wrap modulo N_REQ, first set bit wins
   always_comb begin
      found = 1'b0;
      win   = '0;
      idx   = 0;
      for (int i = 0; i < N_REQ; i++) begin
         idx = int'(ptr_q) + i;
         if (idx >= N_REQ) idx = idx - N_REQ;
         if (!found && bus.req[idx]) begin
            found = 1'b1;
            win   = ID_W'(idx);
         end
      end
   end

   // Next-state and registered-output computation
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      pix_d   = pix_q;
      grant_d = '0;
      id_d    = id_q;
      busy_d  = busy_q;
      fs_d    = 1'b0;
      fd_d    = 1'b0;
      case (state_q)
         IDLE: begin
            busy_d = 1'b0;
            if (found) begin
               // Colour is captured here so later req_color edits do not leak in
               state_d      = STREAM;
               grant_d[win] = 1'b1;
               fs_d         = 1'b1;
               id_d         = win;
               pix_d        = bus.req_color[win*PIXEL_SIZE +: PIXEL_SIZE];
               busy_d       = 1'b1;
               cnt_d        = '0;
               ptr_d        = (win == LAST_ID) ? '0 : win + ID_W'(1);
            end
         end
         STREAM: begin
            // The frame runs to completion even if the requester drops req
            if (bus.pixel_ready) begin
               if (cnt_q == LAST_PIX) begin
                  state_d = DONE;
                  cnt_d   = '0;
                  busy_d  = 1'b0;
                  fd_d    = 1'b1;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         DONE: begin
            // One mandatory cycle here, then IDLE gives the gap between frames
            state_d = IDLE;
            busy_d  = 1'b0;
         end
         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   // State and output registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         cnt_q   <= '0;
         pix_q   <= '0;
         grant_q <= '0;
         id_q    <= '0;
         busy_q  <= 1'b0;
         fs_q    <= 1'b0;
         fd_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
         pix_q   <= pix_d;
         grant_q <= grant_d;
         id_q    <= id_d;
         busy_q  <= busy_d;
         fs_q    <= fs_d;
         fd_q    <= fd_d;
      end
   end

   assign bus.pixel_data  = pix_q;
   assign bus.grant       = grant_q;
   assign bus.active_id   = id_q;
   assign bus.busy        = busy_q;
   assign bus.frame_start = fs_q;
   assign bus.frame_done  = fd_q;
   assign state_dbg       = state_q;
endmodule

// File: tb/tb_ili9341_frame_scheduler.sv
// Bench for ili9341_frame_scheduler at RESOLUTION=8, N_REQ=5. It runs directed
// scenarios and then a randomized stretch. A frame-level reference model
// supplies the expected values.
module tb_ili9341_frame_scheduler;
  localparam int RES   = 8;
  localparam int NR    = 5;
  localparam int PW    = 16;

  logic       clk;
  logic       rst;
  logic [1:0] state_dbg;
  int         checks;
  int         failures;
  int         cyc;

  ili9341_frame_scheduler_if #(.PIXEL_SIZE(PW), .N_REQ(NR)) bus ();

  ili9341_frame_scheduler #(.RESOLUTION(RES), .PIXEL_SIZE(PW), .N_REQ(NR)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Frame-level view: pixels still owed in the current frame, whether the
  // completion pulse is showing, and the rotating priority start.
  int          m_left;
  bit          m_done;
  int          m_ptr;
  int          m_id;
  logic [15:0] m_pix;
  logic [4:0]  m_grant;

  function automatic int pick(input logic [4:0] r, input int start);
    for (int i = 0; i < NR; i++) begin
      int k;
      k = (start + i) % NR;
      if (r[k]) return k;
    end
    return -1;
  endfunction

  task automatic model_update();
    bit was_done;
    int w;
    if (rst) begin
      m_left = 0; m_done = 0; m_ptr = 0; m_id = 0; m_pix = '0; m_grant = '0;
    end else begin
      was_done = m_done;
      m_done   = 0;
      m_grant  = '0;
      if (m_left > 0) begin
        if (bus.pixel_ready) begin
          m_left = m_left - 1;
          if (m_left == 0) m_done = 1;
        end
      end else if (!was_done) begin
        w = pick(bus.req, m_ptr);
        if (w >= 0) begin
          m_grant    = '0;
          m_grant[w] = 1'b1;
          m_left     = RES;
          m_id       = w;
          m_pix      = bus.req_color[w*PW +: PW];
          m_ptr      = (w + 1) % NR;
        end
      end
    end
  endtask

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic timeout_fail(input string tag);
    checks++;
    failures++;
    $error("FAIL %s timed out", tag);
  endtask

  task automatic compare_all();
    check("grant",       32'(bus.grant),       32'(m_grant));
    check("frame_start", 32'(bus.frame_start), 32'(m_grant != 0));
    check("busy",        32'(bus.busy),        32'(m_left > 0));
    check("frame_done",  32'(bus.frame_done),  32'(m_done));
    check("active_id",   32'(bus.active_id),   32'(m_id));
    check("pixel_data",  32'(bus.pixel_data),  32'(m_pix));
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    cyc++;
    compare_all();
  endtask

  task automatic do_reset();
    rst = 1'b1; bus.req = '0; bus.pixel_ready = 1'b0;
    step(); step();
    check("rst_busy",  32'(bus.busy),        32'd0);
    check("rst_grant", 32'(bus.grant),       32'd0);
    check("rst_pix",   32'(bus.pixel_data),  32'd0);
    check("rst_done",  32'(bus.frame_done),  32'd0);
    check("rst_id",    32'(bus.active_id),   32'd0);
    check("rst_fs",    32'(bus.frame_start), 32'd0);
    rst = 1'b0;
  endtask

  task automatic set_color(input int i, input logic [15:0] c);
    bus.req_color[i*PW +: PW] = c;
  endtask

  // ---------------- scoreboard queues ----------------
  logic [4:0] exp_q[$];
  logic [4:0] got_q[$];

  initial begin
    int done_cyc;
    int n;
    checks = 0; failures = 0; cyc = 0;
    rst = 1'b1; bus.req = '0; bus.pixel_ready = 1'b0;
    bus.req_color = '0;
    for (int i = 0; i < NR; i++) set_color(i, 16'($urandom));

    // Single requester, full frame of colour F800
    do_reset();
    set_color(2, 16'hF800);
    bus.req = 5'b00100;
    step();
    check("r33_grant", 32'(bus.grant), 32'h04);
    check("r33_fs",    32'(bus.frame_start), 32'd1);
    bus.req = '0;
    for (int k = 0; k < RES; k++) begin
      bus.pixel_ready = 1'b1;
      step();
      check("r33_pix",  32'(bus.pixel_data), 32'hF800);
      check("r33_done", 32'(bus.frame_done), 32'(k == RES-1));
    end
    bus.pixel_ready = 1'b0;
    step();
    check("r33_done_once", 32'(bus.frame_done), 32'd0);

    // All requesters held: three frames in rotating order, one IDLE cycle apart
    do_reset();
    bus.req = 5'b11111;
    bus.pixel_ready = 1'b1;
    exp_q = '{5'b00001, 5'b00010, 5'b00100};
    got_q.delete();
    done_cyc = -1;
    n = 0;
    while (got_q.size() < 3 && n < 100) begin
      step();
      n++;
      if (bus.frame_done) done_cyc = cyc;
      if (bus.grant != 0) begin
        got_q.push_back(bus.grant);
        if (done_cyc >= 0) check("r34_gap", 32'(cyc - done_cyc), 32'd2);
      end
    end
    if (got_q.size() < 3) timeout_fail("r34_grants");
    while (exp_q.size() > 0 && got_q.size() > 0)
      check("r34_order", 32'(got_q.pop_front()), 32'(exp_q.pop_front()));
    bus.req = '0; bus.pixel_ready = 1'b0;

    // Colour change mid-frame must not leak into the current frame
    do_reset();
    set_color(0, 16'hFFE0);
    bus.req = 5'b00001;
    step();
    bus.req = '0;
    for (int k = 0; k < RES; k++) begin
      bus.pixel_ready = 1'b1;
      if (k == 3) set_color(0, 16'h07FF);
      step();
      check("r35_pix", 32'(bus.pixel_data), 32'hFFE0);
    end
    bus.pixel_ready = 1'b0;
    step();
    bus.req = 5'b00001;
    step();
    check("r35_newcol", 32'(bus.pixel_data), 32'h07FF);
    bus.req = '0;
    for (int k = 0; k < RES + 2; k++) begin
      bus.pixel_ready = 1'b1;
      step();
    end
    bus.pixel_ready = 1'b0;

    // Reset mid-frame aborts without frame_done; priority restarts at 0
    do_reset();
    bus.req = 5'b00010;
    step();
    bus.req = '0;
    for (int k = 0; k < 5; k++) begin
      bus.pixel_ready = 1'b1;
      step();
    end
    bus.pixel_ready = 1'b0;
    rst = 1'b1;
    step();
    check("r36_busy", 32'(bus.busy), 32'd0);
    check("r36_nodone", 32'(bus.frame_done), 32'd0);
    rst = 1'b0;
    step();
    check("r36_nodone2", 32'(bus.frame_done), 32'd0);
    bus.req = 5'b11111;
    step();
    check("r36_grant", 32'(bus.grant), 32'h01);
    bus.req = '0;
    for (int k = 0; k < RES; k++) begin
      bus.pixel_ready = 1'b1;
      step();
      check("r36_done", 32'(bus.frame_done), 32'(k == RES-1));
    end
    bus.pixel_ready = 1'b0;
    step();

    // Strobes in IDLE are ignored
    do_reset();
    bus.pixel_ready = 1'b1;
    for (int k = 0; k < 4; k++) step();
    check("r37_idle_busy", 32'(bus.busy), 32'd0);
    bus.pixel_ready = 1'b0;
    bus.req = 5'b00001;
    step();
    bus.req = '0;
    for (int k = 0; k < RES; k++) begin
      bus.pixel_ready = 1'b1;
      step();
      check("r37_done", 32'(bus.frame_done), 32'(k == RES-1));
    end
    bus.pixel_ready = 1'b0;
    step();

    // Highest index alone, two frames: pointer wraps
    do_reset();
    bus.req = 5'b10000;
    bus.pixel_ready = 1'b1;
    got_q.delete();
    n = 0;
    while (got_q.size() < 2 && n < 60) begin
      step();
      n++;
      if (bus.grant != 0) got_q.push_back(bus.grant);
    end
    if (got_q.size() < 2) timeout_fail("r38_grants");
    while (got_q.size() > 0) check("r38_grant", 32'(got_q.pop_front()), 32'h10);
    bus.req = '0; bus.pixel_ready = 1'b0;

    // Randomized traffic against the model
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      rst = ($urandom_range(0, 149) == 0);
      if ($urandom_range(0, 3) == 0) bus.req = 5'($urandom);
      if ($urandom_range(0, 7) == 0) set_color($urandom_range(0, NR-1), 16'($urandom));
      bus.pixel_ready = ($urandom_range(0, 2) != 0);
      step();
    end
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ili9341_frame_scheduler.md
ILI9341_FRAME_SCHEDULER -- requirements
Module: ili9341_frame_scheduler

Interface
REQ-001 Parameter RESOLUTION, default 320*240: number of pixels per frame.
REQ-002 Parameter PIXEL_SIZE, default 16: RGB565 pixel width.
REQ-003 Parameter N_REQ, default 5: number of frame requesters.
REQ-004 clk  input  1: single clock for all logic.
REQ-005 rst  input  1: synchronous, active-high reset.
REQ-006 req  input  N_REQ: level request per requester; bit i asks for one full frame in colour i.
REQ-007 req_color  input  N_REQ*PIXEL_SIZE: colour of requester i at bits [i*PIXEL_SIZE +: PIXEL_SIZE].
REQ-008 pixel_ready  input  1: one-cycle strobe from the display controller requesting the next pixel.
REQ-009 pixel_data  output  PIXEL_SIZE: pixel presented to the controller.
REQ-010 grant  output  N_REQ: one-hot, one-cycle pulse naming the requester whose frame starts.
REQ-011 active_id  output  $clog2(N_REQ): index of the requester currently being streamed.
REQ-012 busy  output  1: high while a frame is in progress.
REQ-013 frame_start  output  1: one-cycle pulse coincident with grant.
REQ-014 frame_done  output  1: one-cycle pulse after the last pixel is consumed; drives the controller frame_done input.

Function
REQ-015 The FSM SHALL have states IDLE, STREAM and DONE.
REQ-016 In IDLE with req != 0, the FSM SHALL move to STREAM on the next edge, registering grant, frame_start, active_id and the chosen colour on that same edge.
REQ-017 Arbitration SHALL be round-robin: search starts at index ptr and wraps modulo N_REQ; the first set bit wins.
REQ-018 On every grant, ptr SHALL become (winner+1) mod N_REQ.
REQ-019 The colour SHALL be latched at grant; req_color changes during STREAM SHALL NOT affect pixel_data.
REQ-020 In STREAM, busy SHALL be 1 and pixel_data SHALL equal the latched colour.
REQ-021 In STREAM, each pixel_ready SHALL increment a pixel counter of width $clog2(RESOLUTION); there SHALL be no increment without pixel_ready.
REQ-022 A pixel_ready that arrives while the counter equals RESOLUTION-1 SHALL move the FSM to DONE and clear the counter to 0.
REQ-023 In DONE, frame_done SHALL be 1 for exactly one cycle, then the FSM SHALL return to IDLE; busy SHALL be 0 in DONE.
REQ-024 There SHALL be a minimum of one IDLE cycle between frames (back-to-back gap of two cycles from the last pixel_ready to the next grant).
REQ-025 Deassertion of the active requester's req mid-frame SHALL NOT abort the frame.
REQ-026 New or changed req bits during STREAM or DONE SHALL be held pending and arbitrated only in IDLE.
REQ-027 pixel_ready in IDLE or DONE SHALL be ignored; the counter SHALL remain unchanged and pixel_data SHALL hold its last value.
REQ-028 grant and frame_start SHALL be 0 in every cycle other than the grant cycle.
REQ-029 No combinational path SHALL exist from inputs to outputs.

Reset
REQ-030 While rst=1 at a clock edge, the block SHALL enter IDLE with ptr=0, counter=0, pixel_data=0, grant=0, active_id=0, busy=0, frame_start=0 and frame_done=0.
REQ-031 A reset asserted mid-STREAM SHALL abort the frame without a frame_done pulse.
REQ-032 After reset, the first grant SHALL follow REQ-016 with no extra latency.

Verification (RESOLUTION=8, N_REQ=5)
REQ-033 req=00100, colour2=F800 -> grant=00100 and frame_start one cycle later; 8 pixel_ready strobes -> pixel_data=F800 throughout and frame_done pulses once, in the cycle after the 8th strobe.
REQ-034 req=11111 held through three frames from reset -> grants 00001, 00010, 00100 in order; each frame is separated by one IDLE cycle.
REQ-035 Changing colour0 from FFE0 to 07FF mid-frame -> pixel_data stays FFE0 until frame_done; the next frame uses 07FF.
REQ-036 rst=1 after the 5th pixel_ready -> busy=0 next cycle with no frame_done; the next request restarts at counter 0 with ptr=0.
REQ-037 pixel_ready strobes in IDLE, then req=00001 -> frame_done only after 8 strobes in STREAM.
REQ-038 req=10000 only, two consecutive frames -> ptr wraps to 0 and grant=10000 both times.
